serial_bit_deserializer: RTL
============================

Name: serial_bit_deserializer

Overview:
- Receive side of the bit-select path: the mux picks Input[i] by a 3-bit index; this block accepts one bit per strobe and writes it into Data[i], with i advancing 0..WIDTH-1.
- Rebuilds a WIDTH-bit word from a serial stream that was sent LSB-first, index 0 first.
- Sits between a serial source (switch/key strobe or mux-driven link) and downstream parallel logic such as HEX display decode.

Parameters:
- WIDTH, 7, word length in bits; legal range 2..8.
- IDX_W, 3, index width; must satisfy 2^IDX_W >= WIDTH.

Ports:
- Clock  input  1  system clock; all logic on rising edge.
- Resetn  input  1  synchronous, active-low reset.
- Start  input  1  begins a new frame; sampled each cycle.
- BitIn  input  1  serial data bit.
- BitValid  input  1  BitIn is valid this cycle.
- Data  output  WIDTH  assembled word; Data[k] is the k-th received bit.
- Index  output  IDX_W  next bit position to be written.
- Busy  output  1  high while a frame is being collected.
- Done  output  1  one-cycle pulse when the word is complete.

Behaviour:
- Reset (Resetn=0 at a rising edge): state IDLE, Data=0, Index=0, Busy=0, Done=0. Reset takes priority over everything, including mid-frame.
- States:
  - IDLE: Busy=0.
    - Start=1 -> COLLECT; Data cleared to 0; Index=0.
    - BitValid alone is ignored.
  - COLLECT: Busy=1.
    - On BitValid=1: Data[Index] <= BitIn; Index <= Index+1.
    - If Index==WIDTH-1 while BitValid=1: write the bit, Index <= 0, -> DONE.
  - DONE: Busy=0, Done=1 for exactly this one cycle, then -> IDLE.
- Data holds the last word until the next Start.
- Latency: Done asserts in the cycle after the edge that captured the last bit. Data is valid and stable whenever Done=1.
- Start while in COLLECT (with or without BitValid): abort the frame, clear Data, Index=0, stay in COLLECT. The coincident bit is discarded.
- Start while in DONE: Done still pulses this cycle; next state is COLLECT with Data cleared, so the completed word is visible only during the Done cycle.
- BitValid=0 cycles in COLLECT: no change, no timeout.
- Index never exceeds WIDTH-1; wrap happens only via DONE/Start.
- Bits in positions >= WIDTH never exist; no out-of-range writes (unlike the mux default x, there is no x here).

Optional Feature:
- Macro DESER_PARITY_EN.
- Defined:
  - Adds output ParityErr (1 bit) and a PARITY state after the WIDTH data bits.
  - The next BitValid bit is the even-parity bit over Data.
  - Then -> DONE, where ParityErr = (^Data) ^ parity bit, registered and held until the next Start or reset.
  - Reset value 0.
- Undefined: no ParityErr port, no PARITY state; behaviour exactly as above.

Decomposition:
- Shared package/header deser_defs holds:
  - state encodings: IDLE=2'd0, COLLECT=2'd1, PARITY=2'd2, DONE=2'd3
  - default WIDTH/IDX_W constants, shared with the mux-side serializer.
- One natural sub-module: mod_index_counter.
  - Ports: Clock, Resetn, Clear, Enable, Index, Wrap.
  - Counts 0..WIDTH-1 and flags Wrap at WIDTH-1.

Test Plan:
- Reset: hold Resetn=0 two cycles with BitValid toggling -> Data=0, Index=0, Busy=0, Done=0.
- Normal frame: Start, then bits 1,0,1,1,0,0,1 on 7 consecutive BitValid cycles -> Data=7'b1001101 (0x4D), Done high exactly one cycle after the 7th bit, Busy low afterward.
- Gapped valid: same bits with BitValid=0 gaps of 0–3 cycles between bits -> identical Data=0x4D, Index increments only on valid cycles.
- Restart: Start, 4 bits of 1, then Start+BitValid with BitIn=1, then 7 bits of 0 -> Data=0x00, exactly one Done pulse.
- Reset mid-frame: after 3 bits pull Resetn=0 for one cycle -> all outputs 0, and a following BitValid with no Start leaves Data=0.
- With DESER_PARITY_EN: bits 0x4D then parity 0 -> ParityErr=0; repeat with parity 1 -> ParityErr=1 during and after Done.

Source files
------------

// File: rtl/deser_defs.sv
// Shared definitions for the bit-select serial link: state encodings and
// default word geometry used by both the serializer and deserializer sides.
package deser_defs;

  localparam int unsigned DEF_WIDTH = 7;
  localparam int unsigned DEF_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PARITY  = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/mod_index_counter.sv
// Bit-position counter for the deserializer: counts 0..WIDTH-1 on Enable,
// flags Wrap while sitting on the last position, and wraps back to 0.
module mod_index_counter
  import deser_defs::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned IDX_W = DEF_IDX_W
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Clear,
  input  logic             Enable,
  output logic [IDX_W-1:0] Index,
  output logic             Wrap
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  assign Wrap = (Index == LAST);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      Index <= '0;
    end else if (Clear) begin
      Index <= '0;
    end else if (Enable) begin
      Index <= Wrap ? '0 : Index + 1'b1;
    end
  end

endmodule

// File: rtl/serial_bit_deserializer.sv
// Rebuilds a WIDTH-bit word from an LSB-first serial stream, one bit per BitValid.
// Optional trailing even-parity bit and ParityErr output when DESER_PARITY_EN is defined.
module serial_bit_deserializer
  import deser_defs::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned IDX_W = DEF_IDX_W
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic             BitIn,
  input  logic             BitValid,
  output logic [WIDTH-1:0] Data,
  output logic [IDX_W-1:0] Index,
  output logic             Busy,
`ifdef DESER_PARITY_EN
  output logic             ParityErr,
`endif
  output logic             Done
);

  state_t state, state_nx;
  logic   frame_clear;
  logic   data_wr;
  logic   cnt_en;
  logic   wrap;
`ifdef DESER_PARITY_EN
  logic   par_wr;
`endif

  mod_index_counter #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_index (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Clear  (frame_clear),
    .Enable (cnt_en),
    .Index  (Index),
    .Wrap   (wrap)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Start is honoured in every state; in COLLECT/PARITY it aborts the frame
  // and the coincident bit is dropped.
  always_comb begin
    state_nx    = state;
    frame_clear = 1'b0;
    data_wr     = 1'b0;
    cnt_en      = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
`ifdef DESER_PARITY_EN
    par_wr      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (Start) begin
          frame_clear = 1'b1;
          state_nx    = COLLECT;
        end
      end
      COLLECT: begin
        Busy = 1'b1;
        if (Start) begin
          frame_clear = 1'b1;
        end else if (BitValid) begin
          data_wr = 1'b1;
          cnt_en  = 1'b1;
          if (wrap) begin
`ifdef DESER_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = DONE;
`endif
          end
        end
      end
      PARITY: begin
`ifdef DESER_PARITY_EN
        Busy = 1'b1;
        if (Start) begin
          frame_clear = 1'b1;
          state_nx    = COLLECT;
        end else if (BitValid) begin
          par_wr   = 1'b1;
          state_nx = DONE;
        end
`else
        state_nx = IDLE;
`endif
      end
      DONE: begin
        Done = 1'b1;
        if (Start) begin
          frame_clear = 1'b1;
          state_nx    = COLLECT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      Data <= '0;
    end else if (frame_clear) begin
      Data <= '0;
    end else if (data_wr) begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
        if (Index == IDX_W'(k)) begin
          Data[k] <= BitIn;
        end
      end
    end
  end

`ifdef DESER_PARITY_EN
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      ParityErr <= 1'b0;
    end else if (frame_clear) begin
      ParityErr <= 1'b0;
    end else if (par_wr) begin
      ParityErr <= (^Data) ^ BitIn;
    end
  end
`endif

endmodule
